add_one_arbiter: RTL and testbench

- Shares one instance of the existing 9-bit `add_one` incrementer (y = x + 1) among NUM_REQ requesters.
- Round-robin arbitration picks one requester per cycle and drives that requester's operand into `add_one`.
- The result is captured with the requester ID in a one-entry output register, with a valid/ready handshake on the output.
- Sits between the requesting client blocks and the shared incrementer datapath.

---
 rtl/add_one_arb_pkg.sv | 8 +
 rtl/add_one.sv | 7 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/add_one_arbiter.sv | 79 +++++++
 tb/tb_add_one_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/add_one_arb_pkg.sv
// Shared types and widths for the add_one arbiter slice.
package add_one_arb_pkg;
  localparam int DATA_W = 9;
  localparam int STAT_W = 16;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;
  typedef logic [DATA_W-1:0] operand_t;
endpackage

// File: rtl/add_one.sv
// Existing 9-bit incrementer datapath: y = x + 1, wrapping mod 512.
module add_one (
  input  logic [8:0] x,
  output logic [8:0] y
);
  assign y = x + 9'd1;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set req at or after pointer, wrapping mod NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index
);
  logic found;
  int   j;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(pointer) + k) % NUM_REQ;
      if (enable && !found && req[j]) begin
        grant[j] = 1'b1;
        index    = ID_W'(j);
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/add_one_arbiter.sv
// Shares one add_one among NUM_REQ requesters behind a one-entry result slot.
// Optional per-requester grant counters: define ADD_ONE_ARBITER_STATS_EN.
module add_one_arbiter
  import add_one_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_carry,
  output logic [ID_W-1:0]           resp_id,
  input  logic                      resp_ready
`ifdef ADD_ONE_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] grant_count
`endif
);
  slot_state_t        state;
  logic               slot_free, accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx, ptr;
  operand_t           operand, sum;

  // Gating on rst_n keeps grants off for the whole reset window.
  assign slot_free = rst_n && ((state == EMPTY) || resp_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .enable  (slot_free),
    .pointer (ptr),
    .grant   (grant),
    .index   (gnt_idx)
  );

  assign req_ready  = grant;
  assign accept     = |grant;
  assign operand    = req_data[DATA_W*gnt_idx +: DATA_W];
  assign resp_valid = (state == FULL);

  add_one u_add_one (
    .x (operand),
    .y (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      resp_data  <= '0;
      resp_carry <= 1'b0;
      resp_id    <= '0;
      ptr        <= '0;
    end else if (accept) begin
      state      <= FULL;
      resp_data  <= sum;
      resp_carry <= (operand == 9'd511);
      resp_id    <= gnt_idx;
      ptr        <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (resp_ready) begin
      state      <= EMPTY;
    end
  end

`ifdef ADD_ONE_ARBITER_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    cnt <= '0;
      else if (grant[i] && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign grant_count[STAT_W*i +: STAT_W] = cnt;
  end
`endif
endmodule

// File: tb/tb_add_one_arbiter.sv
// Directed + randomized bench for add_one_arbiter against a behavioural slot/round-robin model.
module tb_add_one_arbiter;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*9-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [8:0]     resp_data;
  logic           resp_carry;
  logic [IW-1:0]  resp_id;
  logic           resp_ready;
`ifdef ADD_ONE_ARBITER_STATS_EN
  logic [N*16-1:0] grant_count;
`endif

  add_one_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_carry (resp_carry),
    .resp_id    (resp_id),
    .resp_ready (resp_ready)
`ifdef ADD_ONE_ARBITER_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model: result slot contents and round-robin pointer.
  bit m_valid;
  int m_data, m_carry, m_id, m_ptr, m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_carry = 0; m_id = 0; m_ptr = 0; m_last = -1;
  endtask

  function automatic int model_pick();
    if (m_valid && !resp_ready) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int operand(input int i);
    logic [N*9-1:0] d;
    d = req_data;
    return int'(d[9*i +: 9]);
  endfunction

  // One clock: check grant before the edge, advance model, check slot after.
  task automatic tick();
    int pick, op;
    logic [N-1:0] exp_gnt;
    #1;
    pick    = model_pick();
    exp_gnt = '0;
    if (pick >= 0) exp_gnt[pick] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_gnt));
    op = (pick >= 0) ? operand(pick) : 0;
    @(posedge clk);
    m_last = pick;
    if (pick >= 0) begin
      m_valid = 1;
      m_data  = (op + 1) % 512;
      m_carry = (op == 511) ? 1 : 0;
      m_id    = pick;
      m_ptr   = (pick + 1) % N;
    end else if (m_valid && resp_ready) begin
      m_valid = 0;
    end
    #1;
    check("resp_valid", 32'(resp_valid), 32'(m_valid));
    check("resp_data",  32'(resp_data),  32'(m_data));
    check("resp_carry", 32'(resp_carry), 32'(m_carry));
    check("resp_id",    32'(resp_id),    32'(m_id));
  endtask

  task automatic set_req(input int i, input bit v, input int x);
    req_valid[i]      = v;
    req_data[9*i +: 9] = 9'(x);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '1; req_data = '0; resp_ready = 1'b1;
    model_reset();
    #12;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data",  32'(resp_data),  32'd0);
    check("rst_resp_carry", 32'(resp_carry), 32'd0);
    check("rst_resp_id",    32'(resp_id),    32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;

    // All four held: ids 0,1,2,3 back-to-back, data x+1.
    for (int i = 0; i < N; i++) set_req(i, 1, 10 * (i + 1));
    for (int c = 0; c < N; c++) begin
      tick();
      check("rr_seq_id",   32'(resp_id),   32'(c));
      check("rr_seq_data", 32'(resp_data), 32'(10 * (c + 1) + 1));
    end
    req_valid = '0;
    tick();

    // Single requester 2, x=0.
    set_req(2, 1, 0);
    tick();
    check("single_data", 32'(resp_data), 32'd1);
    check("single_id",   32'(resp_id),   32'd2);
    req_valid = '0;

    // Wrap: 511 on requester 0.
    set_req(0, 1, 511);
    tick();
    check("wrap_data",  32'(resp_data),  32'd0);
    check("wrap_carry", 32'(resp_carry), 32'd1);
    req_valid = '0;
    tick();

    // Backpressure: slot full, resp_ready low for 5 cycles.
    set_req(1, 1, 100);
    tick();
    req_valid = '0;
    for (int i = 0; i < N; i++) set_req(i, 1, 200 + i);
    resp_ready = 1'b0;
    repeat (5) tick();
    check("bp_hold_id", 32'(resp_id), 32'd1);
    resp_ready = 1'b1;
    tick();
    check("bp_release_id", 32'(resp_id), 32'd2);
    req_valid = '0;
    tick();

    // Reset mid-operation with resp_id=1 in the slot.
    set_req(1, 1, 7);
    tick();
    req_valid = '0;
    resp_ready = 1'b0;
    check("pre_rst_id", 32'(resp_id), 32'd1);
    req_valid = '1;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_ready", 32'(req_ready),  32'd0);
    model_reset();
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    resp_ready = 1'b1;
    tick();
    set_req(0, 1, 50); set_req(3, 1, 60);
    tick();
    check("post_rst_ptr_id", 32'(resp_id), 32'd0);
    req_valid = '0;
    tick();

    // Randomized traffic obeying the hold-until-accepted rule.
    for (int c = 0; c < 400; c++) begin
      resp_ready = ($urandom_range(3) != 0);
      if (m_last >= 0) req_valid[m_last] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(2) == 0)
          set_req(i, 1, ($urandom_range(7) == 0) ? 511 : $urandom_range(511));
      tick();
    end
    req_valid = '0;
    tick();

`ifdef ADD_ONE_ARBITER_STATS_EN
    rst_n = 1'b0; model_reset();
    #2;
    check("stat_rst", 32'(grant_count[16*3 +: 16]), 32'd0);
    set_req(3, 1, 5); resp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    req_valid = '0;
    for (int i = 0; i < N; i++)
      check("stat_count", 32'(grant_count[16*i +: 16]), (i == 3) ? 32'hFFFF : 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
